operand_serializer: RTL and testbench

Upstream feeder for the bit-serial adder. It accepts pairs of N-bit parallel operands over a valid/ready handshake and buffers one pair. It emits each pair LSB-first as two serial bit streams (a, b). Before every word it issues a one-cycle clean pulse, so the downstream adder starts each word with a zero carry.

---
 rtl/operand_serializer.sv | 150 +++++++++++++++
 tb/tb_operand_serializer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_serializer.sv
// ---------------------------------------------------------------------------
// operand_serializer
//
// Upstream feeder for a bit-serial adder. Accepts pairs of N-bit operands over
// a valid/ready handshake into a single-entry hold register, then streams each
// pair out LSB-first on (a, b). Every word is preceded by a one-cycle clean
// pulse so the downstream adder starts the word with its carry cleared.
// When a new pair is already waiting at the end of a word, the next clean
// follows the last bit directly, giving one word every N+1 cycles.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high reset
//   in_valid   operand pair on in_a/in_b is valid
//   in_a,in_b  parallel operands (N bits)
//   in_ready   hold register empty and not in reset
//   a, b       serial operand bits, LSB first
//   clean      one-cycle carry-clear pulse before each word
//   bit_valid  a/b carry a real operand bit this cycle
//   bit_last   current a/b bit is the word's MSB
//   busy       a word is in flight or a pair is waiting in the hold register
// ---------------------------------------------------------------------------
module operand_serializer #(
    parameter int N  = 8,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         in_ready,
    output logic         a,
    output logic         b,
    output logic         clean,
    output logic         bit_valid,
    output logic         bit_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAN = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t         state_reg;
    logic           hold_full_reg;
    logic [N-1:0]   hold_a_reg;
    logic [N-1:0]   hold_b_reg;
    logic [N-1:0]   sa_reg;
    logic [N-1:0]   sb_reg;
    logic [CW-1:0]  cnt_reg;

    logic [N-1:0]   sa_next;
    logic [N-1:0]   sb_next;
    logic           accept;
    logic           last_bit;
    logic           in_shift;

    // Shift-down network: each bit takes its upper neighbour, MSB fills with 0.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shift
            if (gi == N - 1) begin : g_top
                assign sa_next[gi] = 1'b0;
                assign sb_next[gi] = 1'b0;
            end else begin : g_low
                assign sa_next[gi] = sa_reg[gi+1];
                assign sb_next[gi] = sb_reg[gi+1];
            end
        end
    endgenerate

    // Accept only into an empty hold register; transfers only read a full one,
    // so a capture and a transfer can never land on the same edge.
    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_reg == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            hold_full_reg <= 1'b0;
            hold_a_reg    <= '0;
            hold_b_reg    <= '0;
            sa_reg        <= '0;
            sb_reg        <= '0;
            cnt_reg       <= '0;
        end else begin
            if (accept) begin
                hold_a_reg    <= in_a;
                hold_b_reg    <= in_b;
                hold_full_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (hold_full_reg) begin
                        sa_reg        <= hold_a_reg;
                        sb_reg        <= hold_b_reg;
                        hold_full_reg <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= CLEAN;
                    end
                end
                CLEAN: begin
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    if (last_bit) begin
                        if (hold_full_reg) begin
                            // Back-to-back: next word's clean follows the MSB.
                            sa_reg        <= hold_a_reg;
                            sb_reg        <= hold_b_reg;
                            hold_full_reg <= 1'b0;
                            cnt_reg       <= '0;
                            state_reg     <= CLEAN;
                        end else begin
                            sa_reg    <= sa_next;
                            sb_reg    <= sb_next;
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        sa_reg  <= sa_next;
                        sb_reg  <= sb_next;
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state; reset masks them in the
    // cycle it is asserted so nothing from a discarded word leaks out.
    assign in_shift  = (state_reg == SHIFT) && !reset;
    assign in_ready  = !hold_full_reg && !reset;
    assign a         = in_shift && sa_reg[0];
    assign b         = in_shift && sb_reg[0];
    assign bit_valid = in_shift;
    assign bit_last  = in_shift && last_bit;
    assign clean     = (state_reg == CLEAN) && !reset;
    assign busy      = ((state_reg != IDLE) || hold_full_reg) && !reset;

endmodule

// File: tb/tb_operand_serializer.sv
// ---------------------------------------------------------------------------
// tb_operand_serializer
//
// Drives an N=8 and an N=1 instance with the same inputs and checks one of
// them at a time (selected by mode). A schedule model predicts every output
// on every cycle: each accepted pair gets a clean cycle at
// max(accept+2, previous clean+N+1), followed by N bit cycles, and it sits in
// the hold register from accept+1 until the cycle before its clean. A serial
// adder fed from the DUT outputs collects per-word operands and sums, which
// directed tests compare against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_operand_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;

    logic r8, a8, b8, c8, v8, l8, y8;
    logic r1, a1, b1, c1, v1, l1, y1;

    always #5 clk = ~clk;

    operand_serializer #(.N(8), .CW(6)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ready(r8), .a(a8), .b(b8), .clean(c8), .bit_valid(v8),
        .bit_last(l8), .busy(y8)
    );

    operand_serializer #(.N(1), .CW(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a[0:0]),
        .in_b(in_b[0:0]), .in_ready(r1), .a(a1), .b(b1), .clean(c1),
        .bit_valid(v1), .bit_last(l1), .busy(y1)
    );

    int mode = 0;   // 0: check the N=8 instance, 1: check the N=1 instance

    wire m_ready = (mode == 1) ? r1 : r8;
    wire m_a     = (mode == 1) ? a1 : a8;
    wire m_b     = (mode == 1) ? b1 : b8;
    wire m_clean = (mode == 1) ? c1 : c8;
    wire m_valid = (mode == 1) ? v1 : v8;
    wire m_last  = (mode == 1) ? l1 : l8;
    wire m_busy  = (mode == 1) ? y1 : y8;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle %0d: wait bound expired", name, cyc);
    endtask

    // ---------------- schedule model ----------------
    typedef struct {
        int         acc;
        int         cs;
        logic [7:0] wa;
        logic [7:0] wb;
    } word_t;

    word_t q[$];
    word_t nw;
    int    last_cs = -1000;
    int    n, bi;
    logic  e_ready, e_a, e_b, e_clean, e_valid, e_last, e_busy, e_hold;

    // ---------------- serial-adder capture ----------------
    logic [7:0] cap_a [32];
    logic [7:0] cap_b [32];
    logic [7:0] cap_s [32];
    int         cap_clean [32];
    int         cap_last [32];
    int         ncap = 0;
    logic [7:0] wa_c, wb_c, ws_c;
    logic       carry, sbit;
    int         bidx = 0;
    int         cur_clean = 0;

    always @(negedge clk) begin
        n = (mode == 1) ? 1 : 8;
        while (q.size() > 0 && q[0].cs + n < cyc) void'(q.pop_front());

        e_ready = 1'b0; e_a = 1'b0; e_b = 1'b0; e_clean = 1'b0;
        e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0; e_hold = 1'b0;
        if (!reset) begin
            foreach (q[k]) begin
                if (q[k].acc + 1 <= cyc && cyc <= q[k].cs - 1) e_hold = 1'b1;
                if (q[k].cs == cyc) e_clean = 1'b1;
                if (q[k].cs < cyc && cyc <= q[k].cs + n) begin
                    bi      = cyc - q[k].cs - 1;
                    e_valid = 1'b1;
                    e_a     = q[k].wa[bi];
                    e_b     = q[k].wb[bi];
                    e_last  = (bi == n - 1);
                end
            end
            e_busy  = e_hold || e_clean || e_valid;
            e_ready = !e_hold;
        end

        chk_bit("in_ready",  m_ready, e_ready);
        chk_bit("a",         m_a,     e_a);
        chk_bit("b",         m_b,     e_b);
        chk_bit("clean",     m_clean, e_clean);
        chk_bit("bit_valid", m_valid, e_valid);
        chk_bit("bit_last",  m_last,  e_last);
        chk_bit("busy",      m_busy,  e_busy);

        if (reset) begin
            q.delete();
            last_cs = -1000;
        end else if (in_valid && e_ready) begin
            nw.acc  = cyc;
            nw.cs   = (cyc + 2 > last_cs + n + 1) ? cyc + 2 : last_cs + n + 1;
            nw.wa   = in_a;
            nw.wb   = in_b;
            last_cs = nw.cs;
            q.push_back(nw);
        end

        // Downstream serial adder driven by the DUT's own stream.
        if (reset) begin
            bidx = 0;
        end else begin
            if (m_clean) begin
                carry = 1'b0; bidx = 0; wa_c = 8'h00; wb_c = 8'h00; ws_c = 8'h00;
                cur_clean = cyc;
            end
            if (m_valid && bidx < 8) begin
                sbit  = m_a ^ m_b ^ carry;
                carry = (m_a & m_b) | (m_a & carry) | (m_b & carry);
                wa_c[bidx] = m_a;
                wb_c[bidx] = m_b;
                ws_c[bidx] = sbit;
                bidx++;
                if (m_last && ncap < 32) begin
                    cap_a[ncap]     = wa_c;
                    cap_b[ncap]     = wb_c;
                    cap_s[ncap]     = ws_c;
                    cap_clean[ncap] = cur_clean;
                    cap_last[ncap]  = cyc;
                    ncap++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] va, input logic [7:0] vb, output int acc);
        acc      = -1;
        in_valid = 1'b1;
        in_a     = va;
        in_b     = vb;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) timeout_fail("send");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int done;
        done = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!m_busy) begin
                done = 1;
                break;
            end
        end
        if (done == 0) timeout_fail("wait_idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: simulation did not finish", cyc);
        $fatal(1);
    end

    initial begin
        int t, ta, tb, tc, base;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_bit("rst_busy",  m_busy,  1'b0);
        chk_bit("rst_ready", m_ready, 1'b1);
        chk_bit("rst_clean", m_clean, 1'b0);
        @(posedge clk);
        #1;

        // 1: single word 0x5A / 0x3C
        base = ncap;
        send(8'h5A, 8'h3C, t);
        wait_idle();
        chk_int("t1_words",   ncap - base, 1);
        chk_int("t1_a",       int'(cap_a[base]), 'h5A);
        chk_int("t1_b",       int'(cap_b[base]), 'h3C);
        chk_int("t1_clean_t", cap_clean[base] - t, 2);
        chk_int("t1_last_t",  cap_last[base] - t, 10);

        // 6: gap after a single word
        send(8'h0F, 8'hF0, t);
        wait_idle();
        repeat (5) begin
            @(negedge clk);
            chk_bit("gap_ready", m_ready, 1'b1);
            chk_bit("gap_valid", m_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // 2: back-to-back 0xFF/0x01 then 0x80/0x80
        base = ncap;
        send(8'hFF, 8'h01, ta);
        send(8'h80, 8'h80, tb);
        wait_idle();
        chk_int("t2_accept_gap", tb - ta, 2);
        chk_int("t2_no_idle",    cap_clean[base+1] - cap_last[base], 1);
        chk_int("t2_sum0",       int'(cap_s[base]), 'h00);
        chk_int("t2_sum1",       int'(cap_s[base+1]), 'h00);

        // 3: backpressure with three queued pairs
        base = ncap;
        send(8'h11, 8'h22, ta);
        send(8'h33, 8'h44, tb);
        send(8'hC3, 8'h96, tc);
        wait_idle();
        chk_int("t3_acc2", tb - ta, 2);
        chk_int("t3_acc3", tc - tb, 9);
        chk_int("t3_a3",   int'(cap_a[base+2]), 'hC3);
        chk_int("t3_b3",   int'(cap_b[base+2]), 'h96);
        chk_int("t3_sum1", int'(cap_s[base]), 'h33);
        chk_int("t3_sum2", int'(cap_s[base+1]), 'h77);
        chk_int("t3_sum3", int'(cap_s[base+2]), 'h59);

        // 4: reset during bit 3 of 0xA5/0x5A with a pair pending
        send(8'hA5, 8'h5A, t);
        send(8'h77, 8'h11, ta);
        base = ncap;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_bit("t4_busy",  m_busy,  1'b0);
        chk_bit("t4_valid", m_valid, 1'b0);
        chk_bit("t4_a",     m_a,     1'b0);
        chk_bit("t4_ready", m_ready, 1'b1);
        repeat (4) @(negedge clk);
        chk_bit("t4_pending_dropped", m_busy, 1'b0);
        chk_int("t4_no_words", ncap - base, 0);
        @(posedge clk);
        #1;
        base = ncap;
        send(8'h3C, 8'hC3, t);
        wait_idle();
        chk_int("t4_a_after", int'(cap_a[base]), 'h3C);
        chk_int("t4_s_after", int'(cap_s[base]), 'hFF);

        // 5: N=1 instance, pairs 1/1, 0/1, 1/0 back-to-back
        mode  = 1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        base = ncap;
        send(8'h01, 8'h01, ta);
        send(8'h00, 8'h01, tb);
        send(8'h01, 8'h00, tc);
        wait_idle();
        chk_int("t5_acc2",   tb - ta, 2);
        chk_int("t5_acc3",   tc - tb, 2);
        chk_int("t5_rate1",  cap_clean[base+1] - cap_clean[base], 2);
        chk_int("t5_rate2",  cap_clean[base+2] - cap_clean[base+1], 2);
        chk_int("t5_shift1", cap_last[base] - cap_clean[base], 1);
        chk_int("t5_sum0",   int'(cap_s[base]), 0);
        chk_int("t5_sum1",   int'(cap_s[base+1]), 1);
        chk_int("t5_sum2",   int'(cap_s[base+2]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
